// File: rtl/cpu_pkg.sv
// Shared CPU types for the multiply/divide sequencer and the control unit.
// Operation encoding, sequencer state and datapath width constants.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIVS  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } md_state_t;

  // Unsigned magnitude of x; the most-negative value maps to itself,
  // which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] md_mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath with sign fix-up.
// Holds {hi,lo} working register; results are presented combinationally.
module muldiv_datapath
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  muldiv_op_t          op_e;
  logic                is_sgn, is_div_in;
  logic [2*XLEN-1:0]   acc, acc_step, prod_neg;
  logic [XLEN-1:0]     dvs;
  logic                is_div, neg_lo, neg_hi;
  logic [XLEN:0]       sum, trial;

  assign op_e      = muldiv_op_t'(op);
  assign is_sgn    = (op_e == MD_MULT) || (op_e == MD_DIVS);
  assign is_div_in = (op_e == MD_DIVU) || (op_e == MD_DIVS);

  // Multiply adds into the upper half then shifts right (LSB-first);
  // divide shifts left and keeps the trial subtraction if it does not borrow.
  assign sum   = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, dvs} & {(XLEN+1){acc[0]}});
  assign trial = acc[2*XLEN-1:XLEN-1] - {1'b0, dvs};

  always_comb begin
    acc_step = acc;
    if (!is_div)
      acc_step = {sum, acc[XLEN-1:1]};
    else if (!trial[XLEN])
      acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {acc[2*XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      dvs    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (load) begin
      is_div <= is_div_in;
      dvs    <= md_mag(b, is_sgn);
      if (is_div_in && b == '0) begin
        // Divide-by-zero goes straight to fix-up with the final result preloaded.
        acc    <= {a, {XLEN{1'b1}}};
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
      end else begin
        acc    <= {{XLEN{1'b0}}, md_mag(a, is_sgn)};
        neg_lo <= is_sgn && (a[XLEN-1] ^ b[XLEN-1]);
        neg_hi <= is_sgn && is_div_in && a[XLEN-1];
      end
    end else if (step) begin
      acc <= acc_step;
    end
  end

  assign prod_neg = -acc;

  always_comb begin
    if (is_div) begin
      res_lo = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      res_hi = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end else begin
      res_lo = neg_lo ? prod_neg[XLEN-1:0] : acc[XLEN-1:0];
      res_hi = neg_lo ? prod_neg[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls dependent
// instructions while the 32-step loop runs.
module muldiv_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hilo_rd,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_t        state, state_nxt;
  muldiv_op_t       op_e;
  logic [CNT_W-1:0] cnt;
  logic             load, step, fixup, div_zero;
  logic [XLEN-1:0]  res_hi, res_lo;

  assign op_e     = muldiv_op_t'(op);
  assign div_zero = ((op_e == MD_DIVU) || (op_e == MD_DIVS)) && (b == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? FIXUP : RUN;
      RUN:     if (cnt == '1) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load  = (state == IDLE) && start;
    step  = (state == RUN);
    fixup = (state == FIXUP);
    busy  = (state != IDLE);
    stall = busy && (start || hilo_rd || hi_we || lo_we);
  end

  // Start takes priority over MTHI/MTLO in IDLE; writes while busy are held off by stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dbz  <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= fixup;
      if (load) begin
        cnt <= '0;
        dbz <= div_zero;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (fixup) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(state == IDLE && start && (hi_we || lo_we)));

  muldiv_datapath u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall,
// MTHI/MTLO interplay, divide-by-zero and mid-operation reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, hilo_rd, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall, done, dbz;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 40) begin
      tick;
      k++;
    end
  endtask

  initial begin
    int k, n_st;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_dbz", {31'b0, dbz}, 32'h0);

    // MULTU max*max, with latency and done-pulse checks
    start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy", {31'b0, busy}, 32'h1);
    chk("multu_hi_hold", hi, 32'h0);
    wait_done(k);
    chk("multu_lat", k, 33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("multu_busy_fall", {31'b0, busy}, 32'h0);
    tick;
    chk("multu_done_once", {31'b0, done}, 32'h0);

    // MULT -3 * 5
    start_op(2'b01, 32'hFFFFFFFD, 32'h00000005);
    wait_done(k);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    // DIVS -7 / 2
    start_op(2'b11, 32'hFFFFFFF9, 32'h00000002);
    wait_done(k);
    chk("divs_lo", lo, 32'hFFFFFFFD);
    chk("divs_hi", hi, 32'hFFFFFFFF);

    // DIVS most-negative / -1
    start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
    wait_done(k);
    chk("divs_min_lo", lo, 32'h80000000);
    chk("divs_min_hi", hi, 32'h0);

    // DIVU by zero: one edge into FIXUP, result on the next
    start_op(2'b10, 32'h00000064, 32'h0);
    chk("dbz_busy", {31'b0, busy}, 32'h1);
    wait_done(k);
    chk("dbz_lat", k, 1);
    chk("dbz_lo", lo, 32'hFFFFFFFF);
    chk("dbz_hi", hi, 32'h00000064);
    chk("dbz_flag", {31'b0, dbz}, 32'h1);
    tick;

    // DIVU 100/7 also clears dbz
    start_op(2'b10, 32'd100, 32'd7);
    chk("dbz_clear", {31'b0, dbz}, 32'h0);
    wait_done(k);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    tick;

    // Stall under hilo_rd with a second start held until IDLE
    op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    tick;
    a = 32'd6; b = 32'd7; hilo_rd = 1'b1;
    #1;
    k = 0; n_st = 0;
    while (busy && k < 40) begin
      if (stall) n_st++;
      tick;
      k++;
    end
    chk("stall_cycles", n_st, 33);
    chk("stall_busy_cycles", k, 33);
    chk("stall_released", {31'b0, stall}, 32'h0);
    chk("stall_done", {31'b0, done}, 32'h1);
    chk("stall_first_lo", lo, 32'd12);
    hilo_rd = 1'b0;
    tick;
    chk("held_start_accept", {31'b0, busy}, 32'h1);
    start = 1'b0;
    wait_done(k);
    chk("held_start_lo", lo, 32'd42);
    chk("held_start_hi", hi, 32'd0);
    tick;

    // MTLO in IDLE, then attempted during RUN
    wdata = 32'h12345678; lo_we = 1'b1;
    tick;
    lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'h12345678);
    start_op(2'b00, 32'd2, 32'd3);
    wdata = 32'hDEADBEEF; lo_we = 1'b1;
    #1;
    chk("mtlo_run_stall", {31'b0, stall}, 32'h1);
    tick;
    chk("mtlo_run_blocked", lo, 32'h12345678);
    lo_we = 1'b0;
    wait_done(k);
    chk("mtlo_after_op", lo, 32'd6);
    tick;

    // Reset at counter 10 abandons the operation
    start_op(2'b00, 32'd5, 32'd5);
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    k = 0;
    repeat (35) begin
      tick;
      if (done) k++;
    end
    chk("midrst_no_done", k, 0);
    chk("midrst_lo_stable", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit that owns the architectural HI/LO registers and sequences the MULT/MULTU/DIV/DIVU instructions for the execute stage. It accepts one operation from the control unit and runs a 32-step shift-add or restoring-divide loop. While it is busy, it holds off dependent instructions (MFHI/MFLO/MTHI/MTLO and any new mult/div) by driving a stall to fetch. It also provides the HI/LO values that the writeback mux selects.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width, equal to log2(XLEN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  execute-stage request to begin the operation in op
op  in  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIVS
a  in  XLEN  rs operand
b  in  XLEN  rt operand
hilo_rd  in  1  current instruction reads HI or LO (MFHI/MFLO)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  XLEN  MTHI/MTLO data
busy  out  1  sequencer not idle
stall  out  1  combinational hold request to fetch/execute
done  out  1  one-cycle pulse when HI/LO have been updated by an operation
dbz  out  1  sticky divide-by-zero flag, cleared by the next accepted start
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (sampled at a clk edge): state=IDLE, hi=0, lo=0, busy=0, done=0, dbz=0, counter=0. Reset mid-operation abandons the operation; no partial result is written.
- States: IDLE, RUN, FIXUP.
- IDLE:
  - On an edge with start=1, latch operands:
    - For signed ops: |a|, |b|, and the result sign flags.
    - For unsigned ops: raw a, b.
  - Then counter=0, dbz=0, state becomes RUN.
  - Divide with b==0: skip to FIXUP directly; the result is lo=32'hFFFFFFFF, hi=a (raw), and dbz=1.
- RUN: one iteration per edge, counter increments. After the edge where counter==XLEN-1, go to FIXUP. That is exactly 32 RUN cycles.
  - Multiply: 64-bit product register {P_hi,P_lo}, shift-add, LSB-first.
  - Divide: restoring division; remainder in the upper half, quotient shifted in from the LSB.
- FIXUP (one edge): apply the sign correction, write hi/lo, pulse done=1 for the following cycle, state becomes IDLE.
  - MULT: negate the 64-bit product if sign(a)^sign(b).
  - DIV: negate the quotient if sign(a)^sign(b); the remainder takes sign(a).
  - Results: {hi,lo}=product; lo=quotient, hi=remainder.
- Latency: start accepted on edge N; hi/lo are valid and done=1 after edge N+33; busy=1 from after edge N through edge N+33.
- busy = (state != IDLE).
- stall = busy & (start | hilo_rd | hi_we | lo_we), combinational.
  - A start while busy is ignored. The requester holds it under stall and it is accepted on the first edge in IDLE.
- MTHI/MTLO:
  - In IDLE, write on the edge.
  - While busy, the write is suppressed (stall).
  - hi_we/lo_we together with start in IDLE: the start wins and the write is dropped. This case is illegal from the CU; it is asserted in simulation.
- hi/lo are stable during RUN: the previous values remain readable only after busy drops.
- Width rules:
  - The product is 2*XLEN bits.
  - Divide subtraction uses XLEN+1 bits.
  - Negation is two's complement within the result width.
  - The most-negative operand (32'h80000000) is handled through the XLEN+1-bit magnitude.
  - DIVS 80000000/FFFFFFFF: lo=80000000, hi=0.

Decomposition:
- Shared package cpu_pkg:
  - muldiv_op_t enum (MD_MULTU, MD_MULT, MD_DIVU, MD_DIVS).
  - md_state_t enum (IDLE, RUN, FIXUP).
  - XLEN constant.
  - The control unit reuses muldiv_op_t.
- One natural sub-module, muldiv_datapath: the 64-bit shift register, XLEN+1 adder/subtractor and negation logic, driven by the FSM step/load/fixup strobes. The FSM, counter, stall and HI/LO registers live in muldiv_sequencer.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF -> after 34 edges hi=FFFFFFFE lo=00000001, done pulses once, busy falls the same cycle.
- MULT a=FFFFFFFD (-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; DIVS a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF.
- DIVU a=00000064 b=0 -> FIXUP after 1 edge: lo=FFFFFFFF hi=00000064 dbz=1; the next start clears dbz.
- hilo_rd held high from cycle 1 after start -> stall=1 through edge N+33, 0 once IDLE; a new start held under stall is accepted on the first IDLE edge.
- MTLO wdata=12345678 in IDLE -> lo=12345678 next cycle; the same during RUN -> stall=1, lo unchanged.
- rst=1 at RUN counter=10 -> next cycle state IDLE, hi=lo=0, busy=0, no done pulse.
